// File: rtl/menu_page_gen.sv
// Menu page renderer: ITEM_NUM text items, key-driven cursor,
// tear-free highlight with optional blink, 3-cycle pixel pipeline.
module menu_page_gen #(
  parameter int          ITEM_NUM   = 4,
  parameter int          CHARS      = 8,
  parameter int          SCALE_LOG2 = 1,
  parameter int          TEXT_X0    = 256,
  parameter int          TEXT_Y0    = 160,
  parameter int          ITEM_PITCH = 48,
  parameter logic [15:0] FG_COLOR   = 16'hFFFF,
  parameter logic [15:0] BG_COLOR   = 16'h0000,
  parameter logic [15:0] HL_COLOR   = 16'h001F,
  parameter bit          BLINK_EN   = 1'b1,
  localparam int         IW = $clog2(ITEM_NUM),
  localparam int         CW = $clog2(CHARS)
) (
  input  logic                 vga_clk,
  input  logic                 sys_rst,
  input  logic [9:0]           screen_x,
  input  logic [9:0]           screen_y,
  input  logic                 key_up,
  input  logic                 key_down,
  input  logic                 key_ent,
  output logic [IW+CW-1:0]     text_addr,
  input  logic [6:0]           char_code,
  output logic [10:0]          font_addr,
  input  logic [7:0]           font_row,
  output logic [15:0]          pix_data,
  output logic [IW-1:0]        sel_idx,
  output logic                 sel_valid
);

  localparam int S = SCALE_LOG2;
  localparam logic [11:0] X0 = 12'(TEXT_X0);
  localparam logic [11:0] X1 = 12'(TEXT_X0 + ((CHARS * 8) << S));
  localparam logic [IW-1:0] LAST = IW'(ITEM_NUM - 1);

  logic [11:0]    w_x;
  logic [11:0]    w_y;
  logic [11:0]    w_relx;
  logic [11:0]    w_rely;
  logic           w_in_x;
  logic           w_in_y;
  logic [IW-1:0]  w_item;
  logic [CW-1:0]  w_col;
  logic [2:0]     w_bit;
  logic [3:0]     w_row;

  assign w_x    = {2'b00, screen_x};
  assign w_y    = {2'b00, screen_y};
  assign w_relx = w_x - X0;
  assign w_in_x = (w_x >= X0) && (w_x < X1);

  // Boxes never overlap (pitch >= box height), so at most one matches
  always_comb begin
    w_in_y = 1'b0;
    w_item = '0;
    w_rely = '0;
    for (int i = 0; i < ITEM_NUM; i++) begin
      if (w_y >= 12'(TEXT_Y0 + i * ITEM_PITCH) &&
          w_y <  12'(TEXT_Y0 + i * ITEM_PITCH + (16 << S))) begin
        w_in_y = 1'b1;
        w_item = IW'(i);
        w_rely = w_y - 12'(TEXT_Y0 + i * ITEM_PITCH);
      end
    end
  end

  assign w_col = CW'(w_relx >> (3 + S));
  assign w_bit = 3'(w_relx >> S);
  assign w_row = 4'(w_rely >> S);

  logic            r_in0;
  logic [IW-1:0]   r_item0;
  logic [2:0]      r_bit0;
  logic [3:0]      r_row0;
  logic [IW+CW-1:0] r_text_addr;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_in0       <= 1'b0;
      r_item0     <= '0;
      r_bit0      <= '0;
      r_row0      <= '0;
      r_text_addr <= '0;
    end else begin
      r_in0       <= w_in_x & w_in_y;
      r_item0     <= w_item;
      r_bit0      <= w_bit;
      r_row0      <= w_row;
      r_text_addr <= {w_item, w_col};
    end
  end

  logic            r_in1;
  logic [IW-1:0]   r_item1;
  logic [2:0]      r_bit1;
  logic [10:0]     r_font_addr;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_in1       <= 1'b0;
      r_item1     <= '0;
      r_bit1      <= '0;
      r_font_addr <= '0;
    end else begin
      r_in1       <= r_in0;
      r_item1     <= r_item0;
      r_bit1      <= r_bit0;
      r_font_addr <= {char_code, r_row0};
    end
  end

  logic [IW-1:0] r_cursor;
  logic [IW-1:0] r_disp;
  logic [4:0]    r_frame;
  logic          r_prev_org;
  logic          r_sel_valid;
  logic [15:0]   r_pix;
  logic          w_org;
  logic          w_fstart;
  logic          w_hl_on;
  logic          w_fg;

  assign w_org    = (screen_x == 10'd0) && (screen_y == 10'd0);
  assign w_fstart = w_org & ~r_prev_org;
  assign w_hl_on  = BLINK_EN ? ~r_frame[4] : 1'b1;
  assign w_fg     = font_row[3'd7 - r_bit1];

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_pix <= '0;
    end else if (!r_in1) begin
      r_pix <= BG_COLOR;
    end else if (w_fg) begin
      r_pix <= FG_COLOR;
    end else if (r_item1 == r_disp && w_hl_on) begin
      r_pix <= HL_COLOR;
    end else begin
      r_pix <= BG_COLOR;
    end
  end

  // Displayed cursor only follows the live one at frame start
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_prev_org <= 1'b0;
      r_frame    <= '0;
      r_disp     <= '0;
    end else begin
      r_prev_org <= w_org;
      if (w_fstart) begin
        r_frame <= r_frame + 5'd1;
        r_disp  <= r_cursor;
      end
    end
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cursor    <= '0;
      r_sel_valid <= 1'b0;
    end else begin
      r_sel_valid <= key_ent;
      if (!key_ent) begin
        if (key_up && !key_down) begin
          r_cursor <= (r_cursor == '0) ? LAST : r_cursor - 1'b1;
        end else if (key_down && !key_up) begin
          r_cursor <= (r_cursor == LAST) ? '0 : r_cursor + 1'b1;
        end
      end
    end
  end

  assign text_addr = r_text_addr;
  assign font_addr = r_font_addr;
  assign pix_data  = r_pix;
  assign sel_idx   = r_cursor;
  assign sel_valid = r_sel_valid;

endmodule
